// File: rtl/sdrc_bank_queue_pkg.sv
// Shared widths, command encodings and FSM state type for the bank queue.
// No logic; types and constants only.
// Imported by sdrc_bank_queue and its testbench.
package sdrc_bank_queue_pkg;

  localparam int DEF_SDR_REQ_ID_W = 4;
  localparam int DEF_REQ_BW       = 12;
  localparam int DEF_DEPTH        = 4;
  localparam int ROW_W            = 12;
  localparam int COL_W            = 12;
  localparam int CNT_W            = 4;

  typedef enum logic [1:0] {
    CMD_PRE = 2'b00,
    CMD_ACT = 2'b01,
    CMD_XFR = 2'b10
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_TRP,
    ST_ACT,
    ST_TRCD,
    ST_XFR
  } state_e;

endpackage

// File: rtl/sdrc_req_fifo.sv
// Generic synchronous in-order FIFO with occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes at full and pops at empty are ignored.
module sdrc_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  // Next pointers, count and storage; power-of-2 depth lets pointers wrap freely.
  always_comb begin
    do_push  = push && (count_q < CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sdrc_bank_queue.sv
// Chunk queue plus per-bank open-row tracking issuing PRE/ACT/XFR with tRP/tRCD waits.
// Latency: row hit pushed in N issues XFR in N+2; waits add cfg+2 cycles after each ack.
// Backpressure: b2r_ack drops at full; b2x_* commands hold stable until x2b_ack.
module sdrc_bank_queue
  import sdrc_bank_queue_pkg::*;
#(
  parameter int SDR_REQ_ID_W = DEF_SDR_REQ_ID_W,
  parameter int REQ_BW       = DEF_REQ_BW,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        cfg_trp_d,
  input  logic [CNT_W-1:0]        cfg_trcd_d,
  input  logic                    r2b_req,
  input  logic [SDR_REQ_ID_W-1:0] r2b_req_id,
  input  logic                    r2b_start,
  input  logic                    r2b_last,
  input  logic                    r2b_wrap,
  input  logic                    r2b_write,
  input  logic [1:0]              r2b_ba,
  input  logic [ROW_W-1:0]        r2b_raddr,
  input  logic [COL_W-1:0]        r2b_caddr,
  input  logic [REQ_BW-1:0]       r2b_len,
  output logic                    b2r_ack,
  output logic                    b2r_arb_ok,
  output logic                    b2x_req,
  output logic [1:0]              b2x_cmd,
  output logic [1:0]              b2x_ba,
  output logic [ROW_W-1:0]        b2x_addr,
  output logic [REQ_BW-1:0]       b2x_len,
  output logic [SDR_REQ_ID_W-1:0] b2x_id,
  output logic                    b2x_start,
  output logic                    b2x_last,
  output logic                    b2x_wrap,
  output logic                    b2x_write,
  input  logic                    x2b_ack,
  input  logic                    x2b_refresh,
  output logic                    b2x_idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [SDR_REQ_ID_W-1:0] id;
    logic                    start;
    logic                    last;
    logic                    wrap;
    logic                    write;
    logic [1:0]              ba;
    logic [ROW_W-1:0]        raddr;
    logic [COL_W-1:0]        caddr;
    logic [REQ_BW-1:0]       len;
  } entry_t;

  typedef struct packed {
    logic                    req;
    logic [1:0]              cmd;
    logic [1:0]              ba;
    logic [ROW_W-1:0]        addr;
    logic [REQ_BW-1:0]       len;
    logic [SDR_REQ_ID_W-1:0] id;
    logic                    start;
    logic                    last;
    logic                    wrap;
    logic                    write;
  } cmd_out_t;

  entry_t                 push_ent, head;
  logic [CW-1:0]          count, count_next;
  logic                   push, pop, empty;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             ov_q, ov_d;
  logic [3:0][ROW_W-1:0]  row_q, row_d;
  cmd_out_t               out_q, out_d;
  logic                   arb_ok_q, arb_ok_d;

  assign b2r_ack    = r2b_req & ~reset & (count < CW'(DEPTH));
  assign push       = b2r_ack;
  assign empty      = (count == '0);
  assign count_next = count + CW'(push) - CW'(pop);
  assign arb_ok_d   = (count_next <= CW'(DEPTH - 2));

  // Pack the incoming chunk attributes into one FIFO entry.
  always_comb begin
    push_ent.id    = r2b_req_id;
    push_ent.start = r2b_start;
    push_ent.last  = r2b_last;
    push_ent.wrap  = r2b_wrap;
    push_ent.write = r2b_write;
    push_ent.ba    = r2b_ba;
    push_ent.raddr = r2b_raddr;
    push_ent.caddr = r2b_caddr;
    push_ent.len   = r2b_len;
  end

  sdrc_req_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  // Command FSM: decode head against the bank table, then walk PRE/TRP/ACT/TRCD/XFR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    row_d   = row_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          out_d.req   = 1'b1;
          out_d.ba    = head.ba;
          out_d.len   = head.len;
          out_d.id    = head.id;
          out_d.start = head.start;
          out_d.last  = head.last;
          out_d.wrap  = head.wrap;
          out_d.write = head.write;
          out_d.addr  = head.raddr;
          if (ov_q[head.ba] && (row_q[head.ba] == head.raddr)) begin
            out_d.cmd  = CMD_XFR;
            out_d.addr = head.caddr;
            state_d    = ST_XFR;
          end else if (ov_q[head.ba]) begin
            out_d.cmd = CMD_PRE;
            state_d   = ST_PRE;
          end else begin
            out_d.cmd = CMD_ACT;
            state_d   = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        if (x2b_ack) begin
          out_d.req        = 1'b0;
          ov_d[out_q.ba]   = 1'b0;
          cnt_d            = cfg_trp_d;
          state_d          = ST_TRP;
        end
      end
      ST_TRP: begin
        if (cnt_q == '0) begin
          out_d.req  = 1'b1;
          out_d.cmd  = CMD_ACT;
          out_d.addr = head.raddr;
          state_d    = ST_ACT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACT: begin
        if (x2b_ack) begin
          out_d.req       = 1'b0;
          ov_d[out_q.ba]  = 1'b1;
          row_d[out_q.ba] = head.raddr;
          cnt_d           = cfg_trcd_d;
          state_d         = ST_TRCD;
        end
      end
      ST_TRCD: begin
        if (cnt_q == '0) begin
          out_d.req  = 1'b1;
          out_d.cmd  = CMD_XFR;
          out_d.addr = head.caddr;
          state_d    = ST_XFR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_XFR: begin
        if (x2b_ack) begin
          out_d.req = 1'b0;
          pop       = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A refresh closes every bank, overriding an ACT recorded this same cycle.
    if (x2b_refresh) begin
      ov_d = '0;
    end
  end

  // FSM, bank table and registered command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ov_q     <= '0;
      row_q    <= '0;
      out_q    <= '0;
      arb_ok_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      row_q    <= row_d;
      out_q    <= out_d;
      arb_ok_q <= arb_ok_d;
    end
  end

  assign b2r_arb_ok = arb_ok_q;
  assign b2x_req    = out_q.req;
  assign b2x_cmd    = out_q.cmd;
  assign b2x_ba     = out_q.ba;
  assign b2x_addr   = out_q.addr;
  assign b2x_len    = out_q.len;
  assign b2x_id     = out_q.id;
  assign b2x_start  = out_q.start;
  assign b2x_last   = out_q.last;
  assign b2x_wrap   = out_q.wrap;
  assign b2x_write  = out_q.write;
  assign b2x_idle   = empty & (state_q == ST_IDLE) & ~r2b_req;

endmodule

// File: tb/tb_sdrc_bank_queue.sv
// Directed bench for sdrc_bank_queue: row hit/miss/closed paths, wait timing,
// full-queue backpressure, split requests, refresh and mid-command reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sdrc_bank_queue;

  localparam logic [1:0] CPRE = 2'b00;
  localparam logic [1:0] CACT = 2'b01;
  localparam logic [1:0] CXFR = 2'b10;
  localparam int TRP  = 3;
  localparam int TRCD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cfg_trp_d, cfg_trcd_d;
  logic        r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write;
  logic [3:0]  r2b_req_id;
  logic [1:0]  r2b_ba;
  logic [11:0] r2b_raddr, r2b_caddr, r2b_len;
  logic        b2r_ack, b2r_arb_ok, b2x_req;
  logic [1:0]  b2x_cmd, b2x_ba;
  logic [11:0] b2x_addr, b2x_len;
  logic [3:0]  b2x_id;
  logic        b2x_start, b2x_last, b2x_wrap, b2x_write;
  logic        x2b_ack, x2b_refresh, b2x_idle;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdrc_bank_queue dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_trp_d   (cfg_trp_d),
    .cfg_trcd_d  (cfg_trcd_d),
    .r2b_req     (r2b_req),
    .r2b_req_id  (r2b_req_id),
    .r2b_start   (r2b_start),
    .r2b_last    (r2b_last),
    .r2b_wrap    (r2b_wrap),
    .r2b_write   (r2b_write),
    .r2b_ba      (r2b_ba),
    .r2b_raddr   (r2b_raddr),
    .r2b_caddr   (r2b_caddr),
    .r2b_len     (r2b_len),
    .b2r_ack     (b2r_ack),
    .b2r_arb_ok  (b2r_arb_ok),
    .b2x_req     (b2x_req),
    .b2x_cmd     (b2x_cmd),
    .b2x_ba      (b2x_ba),
    .b2x_addr    (b2x_addr),
    .b2x_len     (b2x_len),
    .b2x_id      (b2x_id),
    .b2x_start   (b2x_start),
    .b2x_last    (b2x_last),
    .b2x_wrap    (b2x_wrap),
    .b2x_write   (b2x_write),
    .x2b_ack     (x2b_ack),
    .x2b_refresh (x2b_refresh),
    .b2x_idle    (b2x_idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one chunk for one cycle (called at a falling edge); t = cycle of presentation.
  task automatic push(input logic [1:0] ba, input logic [11:0] row, input logic [11:0] col,
                      input logic [11:0] len, input logic [3:0] id, input logic st,
                      input logic la, input logic wp, input logic wr, input logic exp_ack,
                      output int t);
    r2b_ba = ba; r2b_raddr = row; r2b_caddr = col; r2b_len = len; r2b_req_id = id;
    r2b_start = st; r2b_last = la; r2b_wrap = wp; r2b_write = wr; r2b_req = 1'b1;
    #1;
    chk("push_ack", 32'(b2r_ack), 32'(exp_ack));
    t = cyc;
    @(negedge clk);
    r2b_req = 1'b0;
  endtask

  // Wait (bounded) for a command, check it, optionally acknowledge; t = cycle it appeared.
  task automatic wait_cmd(input string tag, input logic [1:0] cmd, input logic [1:0] ba,
                          input logic [11:0] addr, input logic chk_addr, input logic do_ack,
                          output int t);
    int n;
    n = 0;
    while (!b2x_req && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(b2x_req), 32'd1);
    t = cyc;
    chk({tag, "_cmd"}, 32'(b2x_cmd), 32'(cmd));
    chk({tag, "_ba"}, 32'(b2x_ba), 32'(ba));
    if (chk_addr) chk({tag, "_addr"}, 32'(b2x_addr), 32'(addr));
    if (do_ack) begin
      x2b_ack = 1'b1;
      @(posedge clk);
      #1 x2b_ack = 1'b0;
      @(negedge clk);
      chk({tag, "_drop"}, 32'(b2x_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int tp, tp2, ta, tpr, tx, tx2;
    reset = 1'b1; cfg_trp_d = 4'(TRP); cfg_trcd_d = 4'(TRCD);
    r2b_req = 0; r2b_req_id = 0; r2b_start = 0; r2b_last = 0; r2b_wrap = 0; r2b_write = 0;
    r2b_ba = 0; r2b_raddr = 0; r2b_caddr = 0; r2b_len = 0; x2b_ack = 0; x2b_refresh = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req", 32'(b2x_req), 32'd0);
    chk("rst_cmd", 32'(b2x_cmd), 32'd0);
    chk("rst_ba", 32'(b2x_ba), 32'd0);
    chk("rst_addr", 32'(b2x_addr), 32'd0);
    chk("rst_len", 32'(b2x_len), 32'd0);
    chk("rst_flags", 32'({b2x_id, b2x_start, b2x_last, b2x_wrap, b2x_write}), 32'd0);
    chk("rst_arb_ok", 32'(b2r_arb_ok), 32'd1);
    chk("rst_idle", 32'(b2x_idle), 32'd1);
    chk("rst_ack", 32'(b2r_ack), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Closed bank: ACT then XFR after tRCD
    push(2'd1, 12'h012, 12'h040, 12'd8, 4'd3, 1, 1, 0, 1, 1, tp);
    wait_cmd("t2_act", CACT, 2'd1, 12'h012, 1, 1, ta);
    chk("t2_act_lat", 32'(ta - tp), 32'd2);
    wait_cmd("t2_xfr", CXFR, 2'd1, 12'h040, 1, 1, tx);
    chk("t2_trcd_lat", 32'(tx - ta), 32'(TRCD + 2));
    chk("t2_len", 32'(b2x_len), 32'd8);
    chk("t2_write", 32'(b2x_write), 32'd1);
    chk("t2_id", 32'(b2x_id), 32'd3);
    chk("t2_sl", 32'({b2x_start, b2x_last}), 32'd3);
    chk("t2_idle", 32'(b2x_idle), 32'd1);

    // Row hit: XFR only
    push(2'd1, 12'h012, 12'h044, 12'd4, 4'd4, 1, 1, 0, 0, 1, tp);
    wait_cmd("t3_xfr", CXFR, 2'd1, 12'h044, 1, 1, tx);
    chk("t3_lat", 32'(tx - tp), 32'd2);
    chk("t3_len", 32'(b2x_len), 32'd4);
    chk("t3_write", 32'(b2x_write), 32'd0);

    // Row miss: PRE, ACT after tRP, XFR after tRCD
    push(2'd1, 12'h013, 12'h048, 12'd16, 4'd5, 1, 1, 1, 1, 1, tp);
    wait_cmd("t4_pre", CPRE, 2'd1, 12'h000, 0, 1, tpr);
    chk("t4_pre_lat", 32'(tpr - tp), 32'd2);
    wait_cmd("t4_act", CACT, 2'd1, 12'h013, 1, 1, ta);
    chk("t4_trp_lat", 32'(ta - tpr), 32'(TRP + 2));
    wait_cmd("t4_xfr", CXFR, 2'd1, 12'h048, 1, 1, tx);
    chk("t4_trcd_lat", 32'(tx - ta), 32'(TRCD + 2));
    chk("t4_wrap", 32'(b2x_wrap), 32'd1);

    // Fill the queue with no acks; fifth chunk refused
    for (int k = 0; k < 5; k++) begin
      chk("t5_arb_ok", 32'(b2r_arb_ok), 32'(k < 3));
      push(2'd2, 12'h020, 12'(k), 12'd1, 4'(k), 1, 1, 0, 0, (k < 4), tp);
    end
    chk("t5_arb_full", 32'(b2r_arb_ok), 32'd0);
    wait_cmd("t5_act", CACT, 2'd2, 12'h020, 1, 1, ta);
    for (int k = 0; k < 4; k++) begin
      wait_cmd("t5_xfr", CXFR, 2'd2, 12'(k), 1, 1, tx);
      chk("t5_id", 32'(b2x_id), 32'(k));
    end
    chk("t5_idle", 32'(b2x_idle), 32'd1);
    repeat (4) @(negedge clk);
    chk("t5_no_extra", 32'(b2x_req), 32'd0);
    chk("t5_arb_empty", 32'(b2r_arb_ok), 32'd1);

    // Split request: one ACT, two XFRs with flags preserved
    push(2'd3, 12'h100, 12'h010, 12'd12, 4'd6, 1, 0, 0, 1, 1, tp);
    push(2'd3, 12'h100, 12'h01C, 12'd4, 4'd6, 0, 1, 0, 1, 1, tp2);
    wait_cmd("t6_act", CACT, 2'd3, 12'h100, 1, 1, ta);
    wait_cmd("t6_xfr1", CXFR, 2'd3, 12'h010, 1, 1, tx);
    chk("t6_sl1", 32'({b2x_start, b2x_last}), 32'd2);
    chk("t6_len1", 32'(b2x_len), 32'd12);
    wait_cmd("t6_xfr2", CXFR, 2'd3, 12'h01C, 1, 1, tx2);
    chk("t6_sl2", 32'({b2x_start, b2x_last}), 32'd1);
    chk("t6_gap", 32'(tx2 - tx), 32'd2);

    // Refresh closes the open row: next hit must re-activate
    x2b_refresh = 1'b1;
    @(negedge clk);
    x2b_refresh = 1'b0;
    push(2'd3, 12'h100, 12'h020, 12'd2, 4'd7, 1, 1, 0, 0, 1, tp);
    wait_cmd("t7_act", CACT, 2'd3, 12'h100, 1, 1, ta);
    chk("t7_act_lat", 32'(ta - tp), 32'd2);
    wait_cmd("t7_xfr", CXFR, 2'd3, 12'h020, 1, 1, tx);

    // Reset while a command is pending
    push(2'd0, 12'h001, 12'h000, 12'd1, 4'd8, 1, 1, 0, 0, 1, tp);
    wait_cmd("t8_act", CACT, 2'd0, 12'h001, 1, 0, ta);
    reset = 1'b1;
    @(negedge clk);
    chk("t8_req", 32'(b2x_req), 32'd0);
    chk("t8_idle", 32'(b2x_idle), 32'd1);
    chk("t8_arb_ok", 32'(b2r_arb_ok), 32'd1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t8_discard", 32'(b2x_req), 32'd0);
    chk("t8_idle2", 32'(b2x_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
